// File: rtl/display_arbiter_pkg.sv
// Shared constants and types for the display arbiter: digit geometry, owner ids, blank anode code.
package display_arbiter_pkg;

   localparam int unsigned DIGITS  = 8;
   localparam int unsigned BCD_W   = 4;
   localparam int unsigned MAX_REQ = 8;

   typedef logic [2:0] owner_t;
   typedef logic [2:0] idx_t;

   localparam owner_t OWN_CLOCK     = 3'd0;
   localparam owner_t OWN_ALARM     = 3'd1;
   localparam owner_t OWN_STOPWATCH = 3'd2;
   localparam owner_t OWN_SET       = 3'd3;

   localparam logic [DIGITS-1:0] AN_OFF = 8'hFF;

   function automatic logic [DIGITS-1:0] an_sel(idx_t idx);
      return ~(DIGITS'(1) << idx);
   endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Requester/display bundle between the mode logic, the arbiter and the seven-segment driver.
interface display_arbiter_if #(
   parameter int unsigned N_REQ = 4
);
   logic                 scan_tick;
   logic                 blink_tick;
   logic [2:0]           mode_sel;
   logic [N_REQ-1:0]     req;
   logic [N_REQ-1:0]     urgent;
   logic [N_REQ*32-1:0]  frame_data;
   logic [N_REQ*8-1:0]   dot_mask;
   logic [N_REQ*8-1:0]   blink_mask;
   logic [N_REQ-1:0]     grant;
   logic [7:0]           digit_an;
   logic [3:0]           digit_bcd;
   logic                 digit_dp;
   logic                 frame_start;

   modport master (
      output scan_tick, blink_tick, mode_sel, req, urgent, frame_data, dot_mask, blink_mask,
      input  grant, digit_an, digit_bcd, digit_dp, frame_start
   );

   modport slave (
      input  scan_tick, blink_tick, mode_sel, req, urgent, frame_data, dot_mask, blink_mask,
      output grant, digit_an, digit_bcd, digit_dp, frame_start
   );
endinterface

// File: rtl/display_arbiter_owner_arb.sv
// Display owner selection: urgent priority, dwell-based hold, user selection, one-hot grant.
module display_arbiter_owner_arb
   import display_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned HOLD_FRAMES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             eval,
   input  logic [2:0]       mode_sel,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] urgent,
   output owner_t           owner_nxt,
   output logic             change,
   output logic [N_REQ-1:0] grant
);

   localparam int unsigned DW = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
   localparam logic [DW-1:0] HOLD = DW'(HOLD_FRAMES);

   owner_t           owner_q;
   owner_t           pick;
   logic             urg_hit;
   logic [DW-1:0]    dwell_q, dwell_d;
   logic [N_REQ-1:0] grant_q, grant_d;

   always_comb begin
      pick    = owner_q;
      urg_hit = 1'b0;
      // Descending scan so the lowest-index urgent bit is the last writer.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (urgent[i]) begin
            pick    = owner_t'(i);
            urg_hit = 1'b1;
         end
      end
      if (!urg_hit && dwell_q >= HOLD) begin
         pick = OWN_CLOCK;
         for (int i = 0; i < N_REQ; i++) begin
            if (mode_sel == owner_t'(i) && req[i]) pick = owner_t'(i);
         end
      end
   end

   always_comb begin
      owner_nxt = eval ? pick : owner_q;
      change    = eval && (pick != owner_q);
      grant_d   = eval ? (N_REQ'(1) << pick) : grant_q;
      dwell_d   = dwell_q;
      if (eval) begin
         if (change)              dwell_d = '0;
         else if (dwell_q < HOLD) dwell_d = dwell_q + DW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q <= OWN_CLOCK;
         dwell_q <= '0;
         grant_q <= N_REQ'(1);
      end else begin
         owner_q <= owner_nxt;
         dwell_q <= dwell_d;
         grant_q <= grant_d;
      end
   end

   assign grant = grant_q;

endmodule

// File: rtl/display_arbiter.sv
// Shares one 8-digit display among requesters: scan, blink, decimal points, registered outputs.
// Optional DISP_DIM_EN adds a dim_level input that PWM-blanks the anodes.
module display_arbiter
   import display_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned HOLD_FRAMES = 4
) (
   input  logic clk,
   input  logic rst_n,
`ifdef DISP_DIM_EN
   input  logic [2:0] dim_level,
`endif
   display_arbiter_if.slave bus
);

   idx_t              idx_q, idx_use;
   logic              wrap;
   logic              change;
   owner_t            owner_nxt;
   logic              phase_q, phase_d;
   logic              live_q;
   logic [31:0]       fd_sel;
   logic [DIGITS-1:0] dm_sel, bm_sel;
   logic [DIGITS-1:0] an_nxt, an_q;
   logic [BCD_W-1:0]  bcd_q;
   logic              dp_q, fs_q;

   assign wrap = bus.scan_tick && (idx_q == idx_t'(DIGITS - 1));

   display_arbiter_owner_arb #(
      .N_REQ       (N_REQ),
      .HOLD_FRAMES (HOLD_FRAMES)
   ) u_owner_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .eval      (wrap),
      .mode_sel  (bus.mode_sel),
      .req       (bus.req),
      .urgent    (bus.urgent),
      .owner_nxt (owner_nxt),
      .change    (change),
      .grant     (bus.grant)
   );

   // Select using the post-arbitration owner so digit 0 of a new frame shows the new owner.
   always_comb begin
      fd_sel = '0;
      dm_sel = '0;
      bm_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (owner_nxt == owner_t'(i)) begin
            fd_sel = bus.frame_data[i*32 +: 32];
            dm_sel = bus.dot_mask[i*8 +: 8];
            bm_sel = bus.blink_mask[i*8 +: 8];
         end
      end
   end

   always_comb begin
      idx_use = bus.scan_tick ? idx_q + idx_t'(1) : idx_q;
      phase_d = change ? 1'b0 : (phase_q ^ bus.blink_tick);
      an_nxt  = (phase_d && bm_sel[idx_use]) ? AN_OFF : an_sel(idx_use);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= '0;
         phase_q <= 1'b0;
         live_q  <= 1'b0;
         an_q    <= AN_OFF;
         bcd_q   <= '0;
         dp_q    <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         idx_q   <= idx_use;
         phase_q <= phase_d;
         fs_q    <= wrap;
         if (bus.scan_tick) begin
            bcd_q  <= fd_sel[{idx_use, 2'b00} +: BCD_W];
            dp_q   <= dm_sel[idx_use];
            live_q <= 1'b1;
         end
         // Blink edges re-evaluate the lit digit, but never light the display before the first scan.
         if (bus.scan_tick || (bus.blink_tick && live_q)) an_q <= an_nxt;
      end
   end

`ifdef DISP_DIM_EN
   logic [2:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_q + 3'd1;
   end

   assign bus.digit_an = (cnt_q > dim_level) ? AN_OFF : an_q;
`else
   assign bus.digit_an = an_q;
`endif

   assign bus.digit_bcd   = bcd_q;
   assign bus.digit_dp    = dp_q;
   assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: directed literal checks plus random traffic vs a model.
module tb_display_arbiter;
   import display_arbiter_pkg::*;

   localparam int N    = 4;
   localparam int HOLD = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

`ifdef DISP_DIM_EN
   logic [2:0] dim_level = 3'd7;
`endif

   display_arbiter_if #(.N_REQ(N)) bus ();

   display_arbiter #(
      .N_REQ       (N),
      .HOLD_FRAMES (HOLD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef DISP_DIM_EN
      .dim_level (dim_level),
`endif
      .bus       (bus)
   );

   int ncmp = 0;
   int nmis = 0;
   bit done = 0;

   // Reference state: what the display must be showing, derived from the frame rules.
   int       m_idx, m_owner, m_dwell, m_phase, m_live, m_cnt;
   int       m_an, m_dp, m_fs;
   logic [3:0] m_bcd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_idx = 0; m_owner = 0; m_dwell = 0; m_phase = 0; m_live = 0; m_cnt = 0;
      m_an = 'hFF; m_bcd = 4'h0; m_dp = 0; m_fs = 0;
   endfunction

   function automatic void model_step();
      bit st   = bus.scan_tick;
      bit bt   = bus.blink_tick;
      bit wrap = 0;
      bit chg  = 0;
      int pick;
      int ms   = int'(bus.mode_sel);
      m_cnt = (m_cnt + 1) % 8;
      if (st) begin
         wrap  = (m_idx == 7);
         m_idx = (m_idx + 1) % 8;
         if (wrap) begin
            pick = -1;
            for (int i = 0; i < N; i++) if (bus.urgent[i] && pick < 0) pick = i;
            if (pick < 0) begin
               if (m_dwell < HOLD)              pick = m_owner;
               else if (ms < N && bus.req[ms])  pick = ms;
               else                             pick = 0;
            end
            chg = (pick != m_owner);
            if (chg) begin
               m_owner = pick;
               m_dwell = 0;
            end else if (m_dwell < HOLD) begin
               m_dwell++;
            end
         end
      end
      if (chg)     m_phase = 0;
      else if (bt) m_phase = 1 - m_phase;
      if (st) begin
         m_bcd  = 4'(bus.frame_data >> (m_owner * 32 + m_idx * 4));
         m_dp   = int'(bus.dot_mask[m_owner * 8 + m_idx]);
         m_live = 1;
      end
      if (st || (bt && m_live == 1))
         m_an = (m_phase == 1 && bus.blink_mask[m_owner * 8 + m_idx]) ? 'hFF
                                                                      : (~(1 << m_idx)) & 'hFF;
      m_fs = (st && wrap) ? 1 : 0;
   endfunction

   function automatic int exp_an();
`ifdef DISP_DIM_EN
      if (m_cnt > int'(dim_level)) return 'hFF;
`endif
      return m_an;
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!done) begin
            check("grant",       32'(bus.grant),       32'(1 << m_owner));
            check("digit_an",    32'(bus.digit_an),    32'(exp_an()));
            check("digit_bcd",   32'(bus.digit_bcd),   32'(m_bcd));
            check("digit_dp",    32'(bus.digit_dp),    32'(m_dp));
            check("frame_start", 32'(bus.frame_start), 32'(m_fs));
         end
      end
   end

   task automatic scans(input int n);
      repeat (n) begin
         bus.scan_tick = 1'b1;
         @(posedge clk); #1;
         bus.scan_tick = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic blink();
      bus.blink_tick = 1'b1;
      @(posedge clk); #1;
      bus.blink_tick = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bus.scan_tick  = 1'b0;
      bus.blink_tick = 1'b0;
      bus.mode_sel   = 3'd0;
      bus.req        = '0;
      bus.urgent     = '0;
      bus.frame_data = '0;
      bus.dot_mask   = '0;
      bus.blink_mask = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_an",    32'(bus.digit_an),    32'hFF);
      check("rst_grant", 32'(bus.grant),       32'h1);
      check("rst_bcd",   32'(bus.digit_bcd),   32'h0);
      check("rst_dp",    32'(bus.digit_dp),    32'h0);
      check("rst_fs",    32'(bus.frame_start), 32'h0);
      rst_n = 1'b1;

      // Scan walk over owner 0's frame.
      bus.req               = 4'b0001;
      bus.frame_data[31:0]  = 32'h12345678;
      bus.dot_mask[7:0]     = 8'h02;
      scans(1);
      check("walk1_an",  32'(bus.digit_an),  32'hFD);
      check("walk1_bcd", 32'(bus.digit_bcd), 32'h7);
      check("walk1_dp",  32'(bus.digit_dp),  32'h1);
      scans(6);
      check("walk7_an",  32'(bus.digit_an),  32'h7F);
      check("walk7_bcd", 32'(bus.digit_bcd), 32'h1);
      bus.scan_tick = 1'b1;
      @(posedge clk); #1;
      bus.scan_tick = 1'b0;
      check("wrap_an",  32'(bus.digit_an),    32'hFE);
      check("wrap_bcd", 32'(bus.digit_bcd),   32'h8);
      check("wrap_fs",  32'(bus.frame_start), 32'h1);
      @(posedge clk); #1;

      // Blink on digits 0 and 1.
      bus.blink_mask[7:0] = 8'h03;
      blink();
      check("blink_on_d0",  32'(bus.digit_an), 32'hFF);
      blink();
      check("blink_off_d0", 32'(bus.digit_an), 32'hFE);
      scans(1);
      check("blink_d1_lit", 32'(bus.digit_an), 32'hFD);
      blink();
      check("blink_on_d1",  32'(bus.digit_an), 32'hFF);
      blink();
      bus.blink_mask = '0;

      // Hold then switch to the user selection.
      reset_dut();
      bus.req                = 4'b0101;
      bus.mode_sel           = 3'd2;
      bus.frame_data[95:64]  = 32'h0FEDCBA9;
      scans(32);
      check("hold_grant", 32'(bus.grant), 32'h1);
      scans(8);
      check("sel_grant", 32'(bus.grant),     32'h4);
      check("sel_an",    32'(bus.digit_an),  32'hFE);
      check("sel_bcd",   32'(bus.digit_bcd), 32'h9);
      scans(1);
      check("sel_bcd_hex", 32'(bus.digit_bcd), 32'hA);

      // Urgent preemption with zero dwell, then return after the hold.
      bus.urgent = 4'b0010;
      scans(7);
      check("urg_grant", 32'(bus.grant), 32'h2);
      bus.urgent = '0;
      scans(32);
      check("urg_hold_grant", 32'(bus.grant), 32'h2);
      scans(8);
      check("urg_back_grant", 32'(bus.grant), 32'h4);

      // Out-of-range selection and unrequested selection fall back to owner 0.
      bus.mode_sel = 3'd5;
      scans(40);
      check("oor_grant", 32'(bus.grant), 32'h1);
      bus.mode_sel = 3'd2;
      bus.req      = 4'b0001;
      scans(40);
      check("noreq_grant", 32'(bus.grant), 32'h1);

      // Asynchronous reset mid-scan blanks at once.
      scans(3);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_an",    32'(bus.digit_an), 32'hFF);
      check("async_rst_grant", 32'(bus.grant),    32'h1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Random traffic checked every cycle against the model.
      for (int c = 0; c < 5000; c++) begin
         @(posedge clk); #1;
         rst_n          = ($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
         bus.scan_tick  = 1'($urandom_range(0, 1));
         bus.blink_tick = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) bus.req      = 4'($urandom);
         if ($urandom_range(0, 31) == 0) bus.mode_sel = 3'($urandom);
         if ($urandom_range(0, 63) == 0)
            bus.urgent = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
         if ($urandom_range(0, 7) == 0)
            bus.frame_data = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 15) == 0) bus.dot_mask   = 32'($urandom);
         if ($urandom_range(0, 15) == 0) bus.blink_mask = 32'($urandom);
`ifdef DISP_DIM_EN
         if ($urandom_range(0, 63) == 0) dim_level = 3'($urandom);
`endif
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      done = 1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
      $finish;
   end

endmodule
